// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and default frame geometry.
package uart_pkg;

    localparam int unsigned UART_OVERSAMPLE = 16;
    localparam int unsigned UART_DATA_BITS  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Metastability synchronizer for the serial line plus falling-edge detection.
module uart_rx_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic rxd_i,
    output logic rxd_s_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;

    // Preset to the idle level so reset release never looks like a start edge
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_sync <= '1;
            r_hist <= 1'b1;
        end else begin
            r_sync <= SYNC_STAGES'({r_sync, rxd_i});
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    assign rxd_s_o = r_sync[SYNC_STAGES-1];
    assign fall_o  = r_hist & ~r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receive engine: mid-bit sampling on a 16x baud tick, with a
// valid/ack holding register carrying framing-error and overrun status.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE  = UART_OVERSAMPLE,
    parameter int unsigned DATA_BITS   = UART_DATA_BITS,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 rxd_i,
    input  logic                 baud_tick_i,
    output logic                 baud_en_o,
    output logic [DATA_BITS-1:0] rx_data_o,
    output logic                 rx_valid_o,
    input  logic                 rx_ack_i,
    output logic                 frame_err_o,
    output logic                 overrun_o,
    output logic                 busy_o
);

    localparam int unsigned TCNT_W = $clog2(OVERSAMPLE);
    localparam int unsigned BCNT_W = $clog2(DATA_BITS) + 1;
    localparam logic [TCNT_W-1:0] TCNT_MID  = TCNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(OVERSAMPLE - 1);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(DATA_BITS - 1);

    rx_state_e              r_state;
    rx_state_e              w_next_state;
    logic [TCNT_W-1:0]      r_tcnt;
    logic [BCNT_W-1:0]      r_bcnt;
    logic [DATA_BITS-1:0]   r_shift;
    logic [DATA_BITS-1:0]   r_data;
    logic                   r_valid;
    logic                   r_ferr;
    logic                   r_ovr;
    logic                   r_active;

    logic                   w_rxd_s;
    logic                   w_fall;
    logic                   w_mid_tick;
    logic                   w_bit_tick;
    logic                   w_tcnt_clr;
    logic                   w_shift_en;
    logic                   w_done;

    uart_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .rxd_i   (rxd_i),
        .rxd_s_o (w_rxd_s),
        .fall_o  (w_fall)
    );

    assign w_mid_tick = baud_tick_i && (r_tcnt == TCNT_MID);
    assign w_bit_tick = baud_tick_i && (r_tcnt == TCNT_LAST);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:  if (w_fall) w_next_state = START;
            START: if (w_mid_tick) w_next_state = w_rxd_s ? IDLE : DATA;
            DATA:  if (w_bit_tick && (r_bcnt == BCNT_LAST)) w_next_state = STOP;
            STOP:  if (w_bit_tick) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_tcnt_clr = 1'b0;
        w_shift_en = 1'b0;
        w_done     = 1'b0;
        case (r_state)
            IDLE:    w_tcnt_clr = 1'b1;
            START:   w_tcnt_clr = w_mid_tick;
            DATA:    w_shift_en = w_bit_tick;
            STOP:    w_done     = w_bit_tick;
            default: w_tcnt_clr = 1'b1;
        endcase
    end

    // Baud enable tracks the upcoming state so the generator restarts with the frame
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_active <= 1'b0;
        end else begin
            r_active <= (w_next_state != IDLE);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_tcnt  <= '0;
            r_bcnt  <= '0;
            r_shift <= '0;
        end else begin
            if (w_tcnt_clr) begin
                r_tcnt <= '0;
            end else if (baud_tick_i) begin
                r_tcnt <= (r_tcnt == TCNT_LAST) ? '0 : r_tcnt + TCNT_W'(1);
            end
            if (r_state == IDLE) begin
                r_bcnt <= '0;
            end else if (w_shift_en) begin
                r_bcnt <= r_bcnt + BCNT_W'(1);
            end
            if (w_shift_en) begin
                r_shift <= {w_rxd_s, r_shift[DATA_BITS-1:1]};
            end
        end
    end

    // Holding register: a completion without ack while full keeps the old byte
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else if (w_done) begin
            if (r_valid && !rx_ack_i) begin
                r_ovr <= 1'b1;
            end else begin
                r_data  <= r_shift;
                r_ferr  <= ~w_rxd_s;
                r_valid <= 1'b1;
                if (r_valid) begin
                    r_ovr <= 1'b0;
                end
            end
        end else if (rx_ack_i && r_valid) begin
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end
    end

    assign baud_en_o   = r_active;
    assign busy_o      = r_active;
    assign rx_data_o   = r_data;
    assign rx_valid_o  = r_valid;
    assign frame_err_o = r_ferr;
    assign overrun_o   = r_ovr;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: divisor-4 baud generator, serial
// frame driver and a transaction-level model of the holding register.
module tb_uart_receiver;

    localparam int BIT_CLKS   = 64;
    localparam int STOP_TICKS = 8 + 16 * 9;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rxd;
    logic       ack;
    logic       baud_tick;
    logic       baud_en;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    logic [1:0] div_cnt;

    int n_cmp = 0;
    int n_err = 0;

    bit       m_valid;
    bit [7:0] m_data;
    bit       m_ferr;
    bit       m_ovr;

    always #5 clk = ~clk;

    uart_receiver dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .rxd_i       (rxd),
        .baud_tick_i (baud_tick),
        .baud_en_o   (baud_en),
        .rx_data_o   (rx_data),
        .rx_valid_o  (rx_valid),
        .rx_ack_i    (ack),
        .frame_err_o (frame_err),
        .overrun_o   (overrun),
        .busy_o      (busy)
    );

    // Baud generator with divisor 4; its count restarts whenever enable is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt   <= 2'd0;
            baud_tick <= 1'b0;
        end else if (!baud_en) begin
            div_cnt   <= 2'd0;
            baud_tick <= 1'b0;
        end else begin
            div_cnt   <= div_cnt + 2'd1;
            baud_tick <= (div_cnt == 2'd3);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = 8'h00;
        m_ferr  = 1'b0;
        m_ovr   = 1'b0;
    endtask

    task automatic model_complete(input bit [7:0] b, input bit stop, input bit ack_now);
        if (!m_valid || ack_now) begin
            m_data  = b;
            m_ferr  = !stop;
            m_valid = 1'b1;
            m_ovr   = 1'b0;
        end else begin
            m_ovr = 1'b1;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " data"},    32'(rx_data),   32'(m_data));
        chk({tag, " valid"},   32'(rx_valid),  32'(m_valid));
        chk({tag, " ferr"},    32'(frame_err), 32'(m_ferr));
        chk({tag, " overrun"}, 32'(overrun),   32'(m_ovr));
        chk({tag, " busy"},    32'(busy),      32'(0));
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input bit [7:0] b, input bit stop);
        @(negedge clk);
        rxd = 1'b0;
        idle(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            idle(BIT_CLKS);
        end
        rxd = stop;
        idle(BIT_CLKS);
    endtask

    task automatic pulse_ack();
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        if (m_valid) begin
            m_valid = 1'b0;
            m_ferr  = 1'b0;
            m_ovr   = 1'b0;
        end
    endtask

    // Raise ack on the cycle carrying the stop-bit sampling tick
    task automatic ack_on_completion();
        int n   = 0;
        int cyc = 0;
        while (n < STOP_TICKS && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (baud_tick) n++;
            if (n == STOP_TICKS) ack = 1'b1;
        end
        @(negedge clk);
        ack = 1'b0;
        chk("ack window tick count", 32'(n), 32'(STOP_TICKS));
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bit [7:0] b;
        bit       stop;
        bit       saw_idle;

        rst_n = 1'b0;
        rxd   = 1'b1;
        ack   = 1'b0;
        model_reset();
        idle(3);
        check_all("reset");
        chk("reset baud_en", 32'(baud_en), 32'(0));
        rst_n = 1'b1;
        idle(10);
        check_all("post-reset");

        send_frame(8'hA5, 1'b1);
        model_complete(8'hA5, 1'b1, 1'b0);
        idle(4);
        check_all("basic A5");
        pulse_ack();
        check_all("basic ack");

        @(negedge clk);
        rxd = 1'b0;
        idle(20);
        rxd = 1'b1;
        chk("glitch start entered", 32'(busy), 32'(1));
        saw_idle = 1'b0;
        for (int i = 0; i < 33 && !saw_idle; i++) begin
            @(negedge clk);
            if (!baud_en) saw_idle = 1'b1;
        end
        chk("glitch baud_en dropped", 32'(saw_idle), 32'(1));
        idle(100);
        check_all("glitch");

        send_frame(8'h3C, 1'b0);
        model_complete(8'h3C, 1'b0, 1'b0);
        idle(200);
        chk("break busy", 32'(busy), 32'(0));
        rxd = 1'b1;
        idle(BIT_CLKS * 12);
        check_all("frame error 3C");
        pulse_ack();
        send_frame(8'h11, 1'b1);
        model_complete(8'h11, 1'b1, 1'b0);
        idle(4);
        check_all("after break 11");
        pulse_ack();

        send_frame(8'h01, 1'b1);
        model_complete(8'h01, 1'b1, 1'b0);
        send_frame(8'h02, 1'b1);
        model_complete(8'h02, 1'b1, 1'b0);
        idle(4);
        check_all("overrun");
        pulse_ack();
        check_all("overrun ack");

        send_frame(8'h77, 1'b1);
        model_complete(8'h77, 1'b1, 1'b0);
        idle(8);
        fork
            send_frame(8'h55, 1'b1);
            ack_on_completion();
        join
        model_complete(8'h55, 1'b1, 1'b1);
        idle(4);
        check_all("ack on completion");
        pulse_ack();

        for (int f = 0; f < 12; f++) begin
            b    = 8'($urandom);
            stop = ($urandom_range(3) != 0);
            send_frame(b, stop);
            model_complete(b, stop, 1'b0);
            rxd = 1'b1;
            idle(4 + int'($urandom_range(40)));
            check_all($sformatf("random %0d", f));
            if ($urandom_range(1) == 1) begin
                pulse_ack();
                check_all($sformatf("random ack %0d", f));
            end
        end

        send_frame(8'h9E, 1'b1);
        model_complete(8'h9E, 1'b1, 1'b0);
        @(negedge clk);
        rxd = 1'b0;
        idle(BIT_CLKS);
        rxd = 1'b1;
        idle(100);
        chk("mid-data busy", 32'(busy), 32'(1));
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async reset");
        chk("async reset baud_en", 32'(baud_en), 32'(0));
        idle(5);
        rst_n = 1'b1;
        idle(BIT_CLKS * 10);
        check_all("after reset idle");
        send_frame(8'hC3, 1'b1);
        model_complete(8'hC3, 1'b1, 1'b0);
        idle(4);
        check_all("after reset C3");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
